// File: rtl/ahb_mux_pkg.sv
// Shared AHB write-data mux types: HTRANS codes, FSM states, width helper.
// Imported by ahb_onehot_enc and ahb_wdata_mux.
package ahb_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  localparam logic [15:0] BEAT_MAX = 16'hFFFF;

  // index width, never below one bit
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_onehot_enc.sv
// One-hot grant to index encoder with legality flag.
// valid is high only when exactly one bit is set.
module ahb_onehot_enc
  import ahb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2w(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] low_clr;

  // clearing the lowest set bit leaves zero iff at most one bit was set
  assign low_clr = onehot & (onehot - ONE);
  assign valid   = (onehot != '0) && (low_clr == '0);

  // OR of the indices of all set bits; exact when one-hot
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/ahb_wdata_mux.sv
// AHB write-data mux: tracks data-phase owner and steers HWDATA.
// Optional per-byte even parity output with AHB_WDATA_MUX_PARITY_EN.
module ahb_wdata_mux
  import ahb_mux_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int IW          = clog2w(NUM_MASTERS)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NUM_MASTERS-1:0]            HGRANT,
  input  logic [1:0]                        HTRANS,
  input  logic                              HREADY,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic                              CNT_CLR,
  output logic [DATA_WIDTH-1:0]             HWDATA,
  output logic [IW-1:0]                     HMASTER_D,
  output logic                              DATA_ACT,
  output logic                              GRANT_ERR,
`ifdef AHB_WDATA_MUX_PARITY_EN
  output logic [DATA_WIDTH/8-1:0]           HWDATA_PAR,
`endif
  output logic [15:0]                       BEAT_CNT
);

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   owner_q;
  logic            err_q;
  logic [15:0]     cnt_q;
  logic [IW-1:0]   g_idx;
  logic            g_valid;
  logic            accept;
  logic            beat;
  logic [DATA_WIDTH-1:0] slice [NUM_MASTERS];

  ahb_onehot_enc #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_enc (
    .onehot (HGRANT),
    .idx    (g_idx),
    .valid  (g_valid)
  );

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    assign slice[i] = HWDATA_M[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign accept = HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) ||
                   (HTRANS == HTRANS_SEQ));

  assign DATA_ACT = (state_q != ST_IDLE);
  assign beat     = HREADY && DATA_ACT;

  // next data-phase state from ready and accepted transfer
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      HREADY: begin
        state_d = (accept && g_valid) ? ST_DATA : ST_IDLE;
      end
      (!HREADY && state_q == ST_DATA): begin
        state_d = ST_WAIT;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // state register and data-phase owner capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !g_valid;
      if (accept && g_valid) owner_q <= g_idx;
    end
  end

  // saturating beat counter, clear wins over increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (CNT_CLR) begin
      cnt_q <= '0;
    end else if (beat && cnt_q != BEAT_MAX) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign HMASTER_D = owner_q;
  assign GRANT_ERR = err_q;
  assign BEAT_CNT  = cnt_q;
  assign HWDATA    = DATA_ACT ? slice[owner_q] : '0;

`ifdef AHB_WDATA_MUX_PARITY_EN
  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_par
    assign HWDATA_PAR[b] = ^HWDATA[b*8 +: 8];
  end
`endif

endmodule

// File: tb/tb_ahb_wdata_mux.sv
// Randomized self-checking bench for ahb_wdata_mux.
// Reference model tracks bus ownership from the protocol rules.
module tb_ahb_wdata_mux;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [NM-1:0]  HGRANT;
  logic [1:0]     HTRANS;
  logic           HREADY;
  logic [NM*DW-1:0] HWDATA_M;
  logic           CNT_CLR;
  logic [DW-1:0]  HWDATA;
  logic [IW-1:0]  HMASTER_D;
  logic           DATA_ACT;
  logic           GRANT_ERR;
  logic [15:0]    BEAT_CNT;
`ifdef AHB_WDATA_MUX_PARITY_EN
  logic [DW/8-1:0] HWDATA_PAR;
`endif

  logic [DW-1:0] wd [NM];

  int n_tests = 0;
  int n_fail  = 0;

  bit m_act;
  int m_own;
  bit m_err;
  int m_cnt;

  always #5 CLK = ~CLK;

  for (genvar i = 0; i < NM; i++) begin : g_pack
    assign HWDATA_M[i*DW +: DW] = wd[i];
  end

  ahb_wdata_mux #(
    .NUM_MASTERS (NM),
    .DATA_WIDTH  (DW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .HGRANT    (HGRANT),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HWDATA_M  (HWDATA_M),
    .CNT_CLR   (CNT_CLR),
    .HWDATA    (HWDATA),
    .HMASTER_D (HMASTER_D),
    .DATA_ACT  (DATA_ACT),
    .GRANT_ERR (GRANT_ERR),
`ifdef AHB_WDATA_MUX_PARITY_EN
    .HWDATA_PAR(HWDATA_PAR),
`endif
    .BEAT_CNT  (BEAT_CNT)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_wd();
    return m_act ? wd[m_own] : '0;
  endfunction

`ifdef AHB_WDATA_MUX_PARITY_EN
  function automatic logic [DW/8-1:0] par_of(input logic [DW-1:0] x);
    logic [DW/8-1:0] p;
    for (int b = 0; b < DW/8; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(x[b*8+k]);
      p[b] = (ones % 2 == 1);
    end
    return p;
  endfunction
`endif

  task automatic check_all(input string tag);
    chk({tag, "_act"}, 32'(DATA_ACT), 32'(m_act));
    chk({tag, "_own"}, 32'(HMASTER_D), 32'(m_own));
    chk({tag, "_wd"},  HWDATA, exp_wd());
    chk({tag, "_err"}, 32'(GRANT_ERR), 32'(m_err));
    chk({tag, "_cnt"}, 32'(BEAT_CNT), 32'(m_cnt));
`ifdef AHB_WDATA_MUX_PARITY_EN
    chk({tag, "_par"}, 32'(HWDATA_PAR), 32'(par_of(exp_wd())));
`endif
  endtask

  task automatic m_reset();
    m_act = 0;
    m_own = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic rnd_data();
    for (int i = 0; i < NM; i++) wd[i] = $urandom;
  endtask

  // drive one cycle, advance the model, check after the edge
  task automatic step(input logic [NM-1:0] g, input logic [1:0] t,
                      input logic r, input logic c,
                      input string tag);
    bit n_act;
    int n_own;
    bit n_err;
    int n_cnt;
    bit is_xfer;
    HGRANT  = g;
    HTRANS  = t;
    HREADY  = r;
    CNT_CLR = c;
    n_act = m_act;
    n_own = m_own;
    n_err = 0;
    n_cnt = m_cnt;
    if (c) n_cnt = 0;
    else if (r && m_act && m_cnt < 65535) n_cnt = m_cnt + 1;
    if (r) begin
      is_xfer = (t == 2'b10) || (t == 2'b11);
      if (is_xfer && $countones(g) == 1) begin
        n_act = 1;
        for (int i = 0; i < NM; i++) if (g[i]) n_own = i;
      end else begin
        n_act = 0;
      end
      n_err = is_xfer && ($countones(g) != 1);
    end
    @(posedge CLK);
    #1;
    m_act = n_act;
    m_own = n_own;
    m_err = n_err;
    m_cnt = n_cnt;
    check_all(tag);
  endtask

  initial begin
    RST_N   = 1'b0;
    HGRANT  = '0;
    HTRANS  = 2'b00;
    HREADY  = 1'b1;
    CNT_CLR = 1'b0;
    for (int i = 0; i < NM; i++) wd[i] = 32'hA5A5_0000 + i;
    m_reset();
    #12;
    check_all("rst");
    RST_N = 1'b1;

    rnd_data();
    step(4'b0100, 2'b10, 1, 0, "r31_acc");
    chk("r31_own2", 32'(HMASTER_D), 32'd2);
    chk("r31_wd2", HWDATA, wd[2]);
    step(4'b0000, 2'b00, 1, 0, "r31_beat");
    chk("r31_cnt1", 32'(BEAT_CNT), 32'd1);

    rnd_data();
    step(4'b0010, 2'b10, 1, 0, "r32_acc");
    wd[1] = 32'hCAFE0001;
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 2'b10, 0, 0, "r32_wait");
      chk("r32_cafe", HWDATA, 32'hCAFE0001);
    end
    step(4'b0000, 2'b00, 1, 0, "r32_end");

    step(4'b0110, 2'b10, 1, 0, "r33_bad");
    chk("r33_err", 32'(GRANT_ERR), 32'd1);
    step(4'b0000, 2'b00, 1, 0, "r33_after");

    rnd_data();
    step(4'b0001, 2'b10, 1, 0, "r34_m0");
    step(4'b1000, 2'b11, 1, 0, "r34_m3");
    chk("r34_own3", 32'(HMASTER_D), 32'd3);
    step(4'b0000, 2'b00, 1, 0, "r34_end");

    step(4'b0000, 2'b00, 1, 1, "r35_clr");
    step(4'b0001, 2'b10, 1, 0, "r35_acc");
    for (int k = 0; k < 65535; k++) step(4'b0001, 2'b10, 1, 0, "r35_run");
    chk("r35_full", 32'(BEAT_CNT), 32'hFFFF);
    step(4'b0001, 2'b10, 1, 0, "r35_sat");
    chk("r35_sat_v", 32'(BEAT_CNT), 32'hFFFF);
    step(4'b0001, 2'b10, 1, 1, "r35_clrbeat");
    chk("r35_zero", 32'(BEAT_CNT), 32'd0);

    wd[2] = 32'h01030700;
    step(4'b0100, 2'b10, 1, 0, "r36_acc");
    step(4'b0000, 2'b00, 0, 0, "r36_wait");
    #2;
    RST_N = 1'b0;
    #1;
    m_reset();
    check_all("r36_rst");
    RST_N = 1'b1;
    step(4'b0000, 2'b00, 1, 0, "r36_post");

    for (int k = 0; k < 3000; k++) begin
      logic [NM-1:0] g;
      rnd_data();
      if ($urandom_range(0, 7) == 0) g = NM'($urandom);
      else g = NM'(1) << $urandom_range(0, NM - 1);
      step(g, 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
